uart_tx_monitor: RTL and testbench
==================================

# uart_tx_monitor

Serial-side receiver that consumes the `Tx` line leaving `riscv_top` and turns it back into bytes for the simulation bench and on-board loopback checks. It oversamples the line with the system clock, decodes 8N1 UART frames, and buffers decoded bytes in a small show-ahead FIFO. Sticky error flags record framing errors and overflow. It is the downstream stage of the CPU's UART transmit path and is synthesizable.

## Interface
- `SYS_CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate. `CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE` (integer division) must be at least 4.
- `FIFO_DEPTH`, default 16: byte buffer depth. Must be a power of two, at least 2.

- `clk`  in  1  system clock. Everything is on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `rd_en`  in  1  pop the FIFO head. Ignored when `empty`.
- `rd_data`  out  8  FIFO head. Valid whenever `empty` is 0.
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `frame_err`  out  1  sticky: a frame had a low stop bit.
- `overflow`  out  1  sticky: a byte was dropped because the FIFO was full.
- `byte_count`  out  32  total good frames received, wraps modulo 2^32.

## Operation
- `rx` passes through a 2-flop synchronizer. The internal signal is `rx_s`.
- FSM states: IDLE, START, DATA, STOP.
- **IDLE**
  - Wait for `rx_s` = 0.
  - Then clear the bit counter and go to START.
- **START**
  - Count `CLKS_PER_BIT/2` clocks.
  - If `rx_s` is still 0, go to DATA with the counter cleared.
  - If `rx_s` is 1, the start bit was a glitch: return to IDLE. No flag is set.
- **DATA**
  - Every `CLKS_PER_BIT` clocks, sample `rx_s` into the shift register, LSB first.
  - After 8 samples, go to STOP.
- **STOP**
  - After `CLKS_PER_BIT` clocks, sample `rx_s`.
  - Sample is 1: the frame is good. Push the byte if the FIFO is not full, otherwise set `overflow` and drop the byte. `byte_count` increments in both cases.
  - Sample is 0: set `frame_err` and discard the byte.
  - Either way, return to IDLE on the next clock.
- **FIFO**
  - Show-ahead: `rd_data` = mem[rd_ptr].
  - Pointers are log2(`FIFO_DEPTH`)+1 bits wide. `full` and `empty` are decoded from the pointers.
  - Push and pop in the same cycle: both take effect and the occupancy is unchanged. This holds when full: a push with a simultaneous `rd_en` is accepted and `overflow` stays 0. When empty, `rd_en` is ignored and only the push happens.
- **Reset** is synchronous and may arrive mid-frame. It forces:
  - FSM to IDLE;
  - FIFO empty;
  - `frame_err` = 0, `overflow` = 0, `byte_count` = 0;
  - synchronizer flops to 1.

## Timing
- **Reset values:** `empty` = 1, `full` = 0, `rd_data` = don't-care (bench masks it while `empty`), `frame_err` = 0, `overflow` = 0, `byte_count` = 0.
- **Start edge to push:** for `rx` falling at clock edge t0, the push lands at the edge t0 + 2 + `CLKS_PER_BIT`/2 + 9·`CLKS_PER_BIT` (±1). On the following edge, `empty` falls and `rd_data` is valid.
- **Pop:** `rd_en` with !`empty` at edge t; the next byte, or `empty` = 1, is visible after edge t.
- **Flags:** `frame_err` and `overflow` rise on the same edge as the push would have happened. They clear only on `rst`.
- **Back-to-back frames:** a start bit immediately after a stop bit is accepted, because IDLE lasts one clock, which is less than half a bit.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE/START/DATA/STOP);
  - `CLKS_PER_BIT` computation helper;
  - 8N1 frame constants (`DATA_BITS` = 8, stop level 1).
- Sub-module `byte_fifo`, parameterized by width and depth. It holds the pointers and full/empty logic. The receiver FSM, synchronizer and counters live in `uart_tx_monitor`.

## Test plan
Run with `SYS_CLK_FREQ` = 16, `BAUD_RATE` = 1 (`CLKS_PER_BIT` = 16) and `FIFO_DEPTH` = 4.
1. Send bytes 0x55, then 0xA3 -> `rd_data` shows 0x55 with `empty` = 0. After one `rd_en`, it shows 0xA3. `byte_count` = 2. Flags = 0.
2. Drive a 0x41 frame with its stop bit held low -> `frame_err` = 1, `empty` stays 1, `byte_count` = 0. A following good 0x42 is received normally and `frame_err` stays 1.
3. Send 5 bytes 0x01..0x05 with no reads -> `full` = 1, `overflow` = 1, `byte_count` = 5. Reads return 0x01..0x04, then `empty` = 1.
4. Fill the FIFO to 4 entries, then assert `rd_en` on the exact push cycle of a 5th byte 0x66 -> `overflow` = 0, occupancy stays 4, and 0x66 is read last.
5. Pulse `rx` low for 6 clocks -> no byte, no flag, FSM back in IDLE.
6. Assert `rst` mid-DATA of a 0x7E frame, with 2 bytes queued -> next cycle `empty` = 1, `byte_count` = 0, flags = 0. A fresh 0x7E sent afterwards is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART line monitor.
//   - rx_state_t       : receiver FSM states
//   - DATA_BITS        : payload bits per 8N1 frame
//   - STOP_LEVEL       : required line level of a valid stop bit
//   - calc_clks_per_bit: system clocks per serial bit (integer division)
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead FIFO with extra-MSB pointers.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   wr_en     : push wr_data; accepted when not full, or when full with a
//               simultaneous pop
//   rd_en     : pop the head; ignored when empty
//   rd_data   : current head, valid whenever empty is 0
//   empty/full: decoded from the pointers
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Same index with differing wrap bits means every slot is occupied.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the head slot on the same edge, so a push while full is
  // still accepted when it coincides with a pop.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array is deliberately not reset; empty/full come from
  // the pointers, so stale contents are never observable and the array can
  // map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_monitor.sv
// Receives 8N1 UART frames from an oversampled serial line and queues the
// decoded bytes.
//   clk, rst   : system clock, synchronous active-high reset
//   rx         : serial line, idle high, asynchronous to clk
//   rd_en      : pop the FIFO head (ignored when empty)
//   rd_data    : FIFO head, valid while empty is 0
//   empty/full : FIFO status
//   frame_err  : sticky, a frame ended with a low stop bit
//   overflow   : sticky, a good byte was dropped because the FIFO was full
//   byte_count : good frames received, wraps at 2^32
module uart_tx_monitor
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        empty,
  output logic        full,
  output logic        frame_err,
  output logic        overflow,
  output logic [31:0] byte_count
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(SYS_CLK_FREQ, BAUD_RATE);
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int BW           = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  // Two-flop synchronizer; resets to the idle line level so a reset never
  // looks like a start bit.
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  rx_state_t            state, state_next;
  logic [CW-1:0]        clk_cnt, clk_cnt_next;
  logic [BW-1:0]        bit_cnt, bit_cnt_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 frame_good;
  logic                 frame_bad;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_next   = state;
    clk_cnt_next = clk_cnt + CNT_ONE;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    frame_good   = 1'b0;
    frame_bad    = 1'b0;

    unique case (state)
      IDLE: begin
        clk_cnt_next = '0;
        if (!rx_s) begin
          bit_cnt_next = '0;
          state_next   = START;
        end
      end

      // Re-check the line in the middle of the start bit; a line that has
      // gone high again was noise and is dropped silently.
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_next = '0;
          state_next   = rx_s ? IDLE : DATA;
        end
      end

      // Sampling is now aligned to bit centres; LSB arrives first, so shift
      // in from the top.
      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          shift_next   = {rx_s, shift[DATA_BITS-1:1]};
          bit_cnt_next = bit_cnt + BIT_ONE;
          if (bit_cnt == LAST_BIT) state_next = STOP;
        end
      end

      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          state_next   = IDLE;
          if (rx_s == STOP_LEVEL) frame_good = 1'b1;
          else                    frame_bad  = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      clk_cnt <= clk_cnt_next;
      bit_cnt <= bit_cnt_next;
      shift   <= shift_next;
    end
  end

  // A byte is dropped only when the FIFO is full and nothing is popped on
  // the same edge; the counter tracks good frames whether or not stored.
  logic byte_drop;
  assign byte_drop = frame_good && full && !rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      byte_count <= '0;
    end else begin
      if (frame_bad)  frame_err  <= 1'b1;
      if (byte_drop)  overflow   <= 1'b1;
      if (frame_good) byte_count <= byte_count + 32'd1;
    end
  end

  byte_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (frame_good),
    .wr_data (shift),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full)
  );

endmodule

// File: tb/tb_uart_tx_monitor.sv
// Self-checking bench for uart_tx_monitor (CLKS_PER_BIT = 16, depth 4).
// The reference model is a byte queue plus flag/counter variables updated
// once per whole frame from the frame's contents and stop-bit level.
module tb_uart_tx_monitor;

  localparam int CPB         = 16;
  localparam int DEPTH       = 4;
  localparam int FRAME_TICKS = 10 * CPB;
  // Iteration (relative to the edge before the start bit is driven) whose
  // closing edge carries the push: 1 drive-to-edge + 2 + CPB/2 + 9*CPB.
  localparam int PUSH_K      = 2 + CPB / 2 + 9 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        empty;
  logic        full;
  logic        frame_err;
  logic        overflow;
  logic [31:0] byte_count;

  always #5 clk = ~clk;

  uart_tx_monitor #(
    .SYS_CLK_FREQ (16),
    .BAUD_RATE    (1),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .byte_count (byte_count)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  byte unsigned model_q[$];
  bit          m_ferr;
  bit          m_ovf;
  int unsigned m_cnt;
  int          push_k = PUSH_K;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic model_clear();
    model_q.delete();
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic reset_dut();
    rst   = 1'b1;
    rx    = 1'b1;
    rd_en = 1'b0;
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic check_state(input string pfx);
    check({pfx, ":empty"},      32'(empty),     32'(model_q.size() == 0));
    check({pfx, ":full"},       32'(full),      32'(model_q.size() == DEPTH));
    check({pfx, ":frame_err"},  32'(frame_err), 32'(m_ferr));
    check({pfx, ":overflow"},   32'(overflow),  32'(m_ovf));
    check({pfx, ":byte_count"}, byte_count,     m_cnt);
    if (model_q.size() > 0) check({pfx, ":rd_data"}, 32'(rd_data), 32'(model_q[0]));
  endtask

  // Drives one 8N1 frame bit by bit (or only its first n_ticks clocks).
  // With rd_on_push, rd_en is high for the single edge measured as the push
  // edge. seen_k reports the iteration at which empty first fell.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit rd_on_push,
                            input int n_ticks, output int seen_k);
    logic prev_empty;
    seen_k     = -1;
    prev_empty = empty;
    for (int k = 0; k < n_ticks; k++) begin
      int slot;
      slot = k / CPB;
      if (slot == 0)      rx = 1'b0;
      else if (slot <= 8) rx = b[slot-1];
      else                rx = stop_ok;
      rd_en = rd_on_push && (k == push_k);
      tick();
      if (seen_k < 0 && prev_empty && !empty) seen_k = k;
      prev_empty = empty;
    end
    rd_en = 1'b0;
    rx    = 1'b1;
    if (n_ticks == FRAME_TICKS) begin
      if (rd_on_push && model_q.size() > 0) void'(model_q.pop_front());
      if (stop_ok) begin
        m_cnt++;
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else m_ovf = 1'b1;
      end else begin
        m_ferr = 1'b1;
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok);
    int unused_k;
    send_frame(b, stop_ok, 1'b0, FRAME_TICKS, unused_k);
    // A low stop bit leaves the line low; let it recover before the next frame.
    if (!stop_ok) idle(2 * CPB);
  endtask

  task automatic do_reads(input string pfx, input int n);
    for (int i = 0; i < n; i++) begin
      if (model_q.size() > 0) check({pfx, ":head"}, 32'(rd_data), 32'(model_q[0]));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      if (model_q.size() > 0) void'(model_q.pop_front());
      check({pfx, ":empty_after_pop"}, 32'(empty), 32'(model_q.size() == 0));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    rst   = 1'b1;
    rx    = 1'b1;
    rd_en = 1'b0;
    model_clear();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_state("reset");

    // Two back-to-back frames; first one also measures the push edge.
    send_frame(8'h55, 1'b1, 1'b0, FRAME_TICKS, seen);
    check("push_edge_in_window", 32'(seen >= PUSH_K - 1 && seen <= PUSH_K + 1), 32'd1);
    if (seen >= 0) push_k = seen;
    send(8'hA3, 1'b1);
    check_state("t1");
    do_reads("t1", 2);
    check_state("t1_drained");

    // Low stop bit, then a good frame.
    send(8'h41, 1'b0);
    check_state("t2_bad");
    send(8'h42, 1'b1);
    check_state("t2_good");
    do_reads("t2", 1);

    // Five frames into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    check_state("t3_full");
    do_reads("t3", 5);
    check_state("t3_drained");

    // Full FIFO with a pop on the exact push edge of the fifth byte.
    reset_dut();
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1'b1);
    check_state("t4_filled");
    send_frame(8'h66, 1'b1, 1'b1, FRAME_TICKS, seen);
    check_state("t4_swap");
    do_reads("t4", 5);

    // Short low glitch: nothing received; a following frame still decodes.
    rx = 1'b0;
    repeat (6) tick();
    idle(3 * CPB);
    check_state("t5_glitch");
    send(8'h5A, 1'b1);
    check_state("t5_after");
    do_reads("t5", 1);

    // Reset in the middle of a frame's data bits with two bytes queued.
    send(8'hC1, 1'b1);
    send(8'hC2, 1'b1);
    check_state("t6_queued");
    send_frame(8'h7E, 1'b1, 1'b0, 3 * CPB + 5, seen);
    reset_dut();
    check_state("t6_rst");
    idle(CPB);
    send(8'h7E, 1'b1);
    check_state("t6_fresh");
    do_reads("t6", 1);

    // Randomized traffic.
    reset_dut();
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      bit ok;
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send(b, ok);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, CPB));
      check_state("rand");
      do_reads("rand", $urandom_range(0, 3));
    end
    do_reads("final", DEPTH);
    check_state("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
